agex_muldiv_ctrl: RTL and testbench
===================================

Name: agex_muldiv_ctrl

Overview:
Sequencer for a shared iterative multiply/divide unit attached to the AGEX stage. It accepts one RV32M op from AGEX, stalls the pipeline with `stall_AGEX` while it iterates, and returns one result and destination tag for the AGEX latch. It uses a radix-2 shift-add multiplier and a restoring divider. A branch flush kills the op in flight.

Parameters:
DBITS, 32, operand/result width (design is exercised at 32 only)
REGNOBITS, 5, destination register ID width
CNTBITS, 6, iteration counter width (must hold DBITS)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
req_valid  in  1  AGEX presents an M-extension op; held stable while stall_AGEX=1
req_op  in  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
req_rs1  in  DBITS  operand A (dividend / multiplicand)
req_rs2  in  DBITS  operand B (divisor / multiplier)
req_rd  in  REGNOBITS  destination register
flush  in  1  branch-mispredict kill from AGEX
req_ready  out  1  high only in IDLE
stall_AGEX  out  1  AGEX/DE/FE must hold their latches
resp_valid  out  1  one-cycle result strobe
resp_result  out  DBITS  result
resp_rd  out  REGNOBITS  destination tag of the result

Behaviour:
- Clocking: one clock, `clk`. `reset` is synchronous and active-high and takes priority over `flush` and over every other input.
- Reset state: state=IDLE, counter=0, resp_valid=0, resp_result=0, resp_rd=0, internal accumulators=0.
- States and transitions:
  - IDLE:
    - Accept when req_valid && req_ready && !flush.
    - Latch op, rd, operand magnitudes and sign flags.
    - If the op is a divide/remainder with rs2==0, or is DIV/REM with rs1=0x80000000 and rs2=0xFFFFFFFF, go to DONE (fast path).
    - Otherwise counter=0 and go to CALC.
  - CALC:
    - One iteration per cycle; counter increments.
    - After the iteration with counter==DBITS-1, go to FIX.
  - FIX: apply sign correction and select the high or low half; go to DONE.
  - DONE:
    - resp_valid=1 for exactly this cycle; resp_result and resp_rd are registered.
    - Next state IDLE.
    - req_ready=0, so the still-asserted req_valid is never re-accepted.
- stall_AGEX is combinational: 1 in CALC and FIX; 1 in IDLE when req_valid && !flush; 0 in DONE (AGEX latch advances that cycle).
- Latency, with acceptance at edge T:
  - Normal ops: CALC covers T+1..T+32, FIX at T+33, DONE at T+34.
  - Fast path: DONE at T+1.
- Flush:
  - In any state, the next state is IDLE.
  - resp_valid is never asserted for a killed op.
  - flush in the DONE cycle suppresses resp_valid.
- Multiply arithmetic:
  - Signed operands are converted to magnitudes: MUL/MULH treat both as signed; MULHSU treats rs1 as signed and rs2 as unsigned; MULHU treats both as unsigned.
  - A 64-bit product is accumulated in CALC.
  - FIX negates the 64-bit product if the operand signs differ.
  - MUL returns bits [31:0]; the other multiply ops return [63:32].
- Divide arithmetic:
  - Restoring divide on magnitudes (signed for DIV/REM, unsigned for DIVU/REMU).
  - Quotient sign = sign(rs1) XOR sign(rs2); remainder sign = sign(rs1).
  - Divide by zero: quotient=0xFFFFFFFF, remainder=rs1.
  - Overflow case: quotient=0x80000000, remainder=0.
- Widths: all intermediate arithmetic is unsigned with explicit two's-complement negation. No truncation before FIX.

Test Plan:
- MUL rs1=7, rs2=0xFFFFFFFD, accepted at T -> stall_AGEX=1 for T..T+33; resp_valid only at T+34; result 0xFFFFFFEB; resp_rd=req_rd.
- MULH 0x80000000×0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD. REM 0xFFFFFFF9/2 -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU 100/7 -> 2. Each at T+34.
- DIVU 5/0 -> 0xFFFFFFFF at T+1. REMU 5/0 -> 5. DIV 0x80000000/0xFFFFFFFF -> 0x80000000 at T+1. REM of the same -> 0.
- MUL accepted at T, flush=1 at T+10 -> IDLE at T+11; req_ready=1; no resp_valid through T+40. A new request at T+11 is accepted and completes at T+45.
- reset=1 during CALC (T+5) -> at the next edge state=IDLE, resp_valid=0, resp_result=0, resp_rd=0; stall_AGEX=0 when req_valid=0.

Source files
------------

// File: rtl/agex_muldiv_ctrl.sv
// Iterative RV32M sequencer: radix-2 shift-add multiply, restoring divide.
// One op at a time; holds AGEX via stall_AGEX while iterating; flush kills the op in flight.
module agex_muldiv_ctrl #(
  parameter int DBITS     = 32,
  parameter int REGNOBITS = 5,
  parameter int CNTBITS   = 6
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  input  logic [2:0]           req_op,
  input  logic [DBITS-1:0]     req_rs1,
  input  logic [DBITS-1:0]     req_rs2,
  input  logic [REGNOBITS-1:0] req_rd,
  input  logic                 flush,
  output logic                 req_ready,
  output logic                 stall_AGEX,
  output logic                 resp_valid,
  output logic [DBITS-1:0]     resp_result,
  output logic [REGNOBITS-1:0] resp_rd
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  localparam logic [DBITS-1:0] MIN_VAL = {1'b1, {(DBITS-1){1'b0}}};

  state_t                 state_q, state_d;
  logic [CNTBITS-1:0]     cnt_q, cnt_d;
  logic [2:0]             op_q, op_d;
  logic [REGNOBITS-1:0]   rd_q, rd_d;
  logic [DBITS-1:0]       opnd_q, opnd_d;
  logic [2*DBITS-1:0]     acc_q, acc_d;
  logic                   neg_q, neg_d, neg_rem_q, neg_rem_d;
  logic                   resp_valid_q, resp_valid_d;
  logic [DBITS-1:0]       resp_result_q, resp_result_d;
  logic [REGNOBITS-1:0]   resp_rd_q, resp_rd_d;

  logic                   sign1, sign2, div_zero, div_ovf;
  logic [DBITS-1:0]       mag1, mag2;
  logic [DBITS:0]         mul_sum, div_diff;
  logic [2*DBITS:0]       div_shl;
  logic [2*DBITS-1:0]     mul_next, div_next, prod_fix;
  logic [DBITS-1:0]       quo_fix, rem_fix, fix_result;

  always_comb begin
    // Signedness per op: MUL/MULH both, MULHSU rs1 only, MULHU none; DIV/REM signed, DIVU/REMU not.
    sign1    = req_rs1[DBITS-1] & (req_op[2] ? ~req_op[0] : (req_op != 3'd3));
    sign2    = req_rs2[DBITS-1] & (req_op[2] ? ~req_op[0] : ~req_op[1]);
    mag1     = sign1 ? ({DBITS{1'b0}} - req_rs1) : req_rs1;
    mag2     = sign2 ? ({DBITS{1'b0}} - req_rs2) : req_rs2;
    div_zero = (req_rs2 == {DBITS{1'b0}});
    div_ovf  = ~req_op[0] && (req_rs1 == MIN_VAL) && (req_rs2 == {DBITS{1'b1}});

    // acc holds {partial product, multiplier} or {remainder, dividend/quotient}.
    mul_sum  = {1'b0, acc_q[2*DBITS-1:DBITS]} + (acc_q[0] ? {1'b0, opnd_q} : {(DBITS+1){1'b0}});
    mul_next = {mul_sum, acc_q[DBITS-1:1]};
    div_shl  = {acc_q, 1'b0};
    div_diff = div_shl[2*DBITS:DBITS] - {1'b0, opnd_q};
    div_next = div_diff[DBITS] ? div_shl[2*DBITS-1:0]
                               : {div_diff[DBITS-1:0], div_shl[DBITS-1:1], 1'b1};

    prod_fix = neg_q ? ({(2*DBITS){1'b0}} - acc_q) : acc_q;
    quo_fix  = neg_q ? ({DBITS{1'b0}} - acc_q[DBITS-1:0]) : acc_q[DBITS-1:0];
    rem_fix  = neg_rem_q ? ({DBITS{1'b0}} - acc_q[2*DBITS-1:DBITS]) : acc_q[2*DBITS-1:DBITS];
    if (!op_q[2])
      fix_result = (op_q == 3'd0) ? prod_fix[DBITS-1:0] : prod_fix[2*DBITS-1:DBITS];
    else
      fix_result = op_q[1] ? rem_fix : quo_fix;
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    op_d          = op_q;
    rd_d          = rd_q;
    opnd_d        = opnd_q;
    acc_d         = acc_q;
    neg_d         = neg_q;
    neg_rem_d     = neg_rem_q;
    resp_valid_d  = 1'b0;
    resp_result_d = resp_result_q;
    resp_rd_d     = resp_rd_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid && !flush) begin
          op_d      = req_op;
          rd_d      = req_rd;
          neg_d     = sign1 ^ sign2;
          neg_rem_d = sign1;
          cnt_d     = {CNTBITS{1'b0}};
          opnd_d    = req_op[2] ? mag2 : mag1;
          acc_d     = {{DBITS{1'b0}}, (req_op[2] ? mag1 : mag2)};
          if (req_op[2] && (div_zero || div_ovf)) begin
            state_d       = S_DONE;
            resp_valid_d  = 1'b1;
            resp_rd_d     = req_rd;
            if (div_zero)
              resp_result_d = req_op[1] ? req_rs1 : {DBITS{1'b1}};
            else
              resp_result_d = req_op[1] ? {DBITS{1'b0}} : MIN_VAL;
          end else begin
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        acc_d = op_q[2] ? div_next : mul_next;
        cnt_d = cnt_q + CNTBITS'(1);
        if (cnt_q == CNTBITS'(DBITS-1))
          state_d = S_FIX;
      end
      S_FIX: begin
        state_d       = S_DONE;
        resp_valid_d  = 1'b1;
        resp_result_d = fix_result;
        resp_rd_d     = rd_q;
      end
      default: state_d = S_IDLE;
    endcase
    if (flush) begin
      state_d      = S_IDLE;
      resp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      op_q          <= '0;
      rd_q          <= '0;
      opnd_q        <= '0;
      acc_q         <= '0;
      neg_q         <= 1'b0;
      neg_rem_q     <= 1'b0;
      resp_valid_q  <= 1'b0;
      resp_result_q <= '0;
      resp_rd_q     <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      op_q          <= op_d;
      rd_q          <= rd_d;
      opnd_q        <= opnd_d;
      acc_q         <= acc_d;
      neg_q         <= neg_d;
      neg_rem_q     <= neg_rem_d;
      resp_valid_q  <= resp_valid_d;
      resp_result_q <= resp_result_d;
      resp_rd_q     <= resp_rd_d;
    end
  end

  // A flush landing in the DONE cycle must still suppress the strobe.
  assign resp_valid  = resp_valid_q & ~flush;
  assign resp_result = resp_result_q;
  assign resp_rd     = resp_rd_q;
  assign req_ready   = (state_q == S_IDLE);
  assign stall_AGEX  = (state_q == S_CALC) || (state_q == S_FIX) ||
                       ((state_q == S_IDLE) && req_valid && !flush);

endmodule

// File: tb/tb_agex_muldiv_ctrl.sv
// Scoreboard bench for agex_muldiv_ctrl: directed + random RV32M ops against an arithmetic model.
module tb_agex_muldiv_ctrl;
  localparam int DBITS = 32, REGNOBITS = 5, CNTBITS = 6;

  logic                 clk = 1'b0;
  logic                 reset, req_valid, flush;
  logic [2:0]           req_op;
  logic [DBITS-1:0]     req_rs1, req_rs2;
  logic [REGNOBITS-1:0] req_rd;
  logic                 req_ready, stall_AGEX, resp_valid;
  logic [DBITS-1:0]     resp_result;
  logic [REGNOBITS-1:0] resp_rd;

  agex_muldiv_ctrl #(.DBITS(DBITS), .REGNOBITS(REGNOBITS), .CNTBITS(CNTBITS)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_op(req_op),
    .req_rs1(req_rs1), .req_rs2(req_rs2), .req_rd(req_rd), .flush(flush),
    .req_ready(req_ready), .stall_AGEX(stall_AGEX), .resp_valid(resp_valid),
    .resp_result(resp_result), .resp_rd(resp_rd)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [31:0] res; logic [4:0] rd; int due; } exp_t;
  exp_t exp_q[$];
  int tests = 0, fails = 0;

  localparam logic [31:0] MINV = 32'h8000_0000;

  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] sa, sb, ua, ub, p;
    logic signed [31:0] x, y, r;
    sa = {{32{a[31]}}, a}; sb = {{32{b[31]}}, b};
    ua = {32'b0, a};       ub = {32'b0, b};
    x = a; y = b;
    case (op)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == MINV && b == 32'hFFFF_FFFF) return MINV;
        r = x / y; return r;
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == MINV && b == 32'hFFFF_FFFF) return 32'h0;
        r = x % y; return r;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic bit is_fast(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    return op[2] && (b == 0 || (!op[0] && a == MINV && b == 32'hFFFF_FFFF));
  endfunction

  function automatic logic [31:0] rnd_opnd();
    case ($urandom_range(0, 9))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return MINV;
      4: return $urandom_range(0, 20);
      default: return $urandom();
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    req_valid = 1'b1; req_op = op; req_rs1 = a; req_rs2 = b; req_rd = rd;
  endtask

  // Wait for acceptance of the driven op, log its expected response, and follow the stall window.
  task automatic complete(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    int n, st, t_acc;
    bit fast;
    exp_t e;
    #1;
    n = 0;
    while (!req_ready && n < 100) begin @(negedge clk); #1; n++; end
    if (!req_ready) begin
      chk("accept_timeout", 32'(req_ready), 32'd1);
      req_valid = 1'b0;
      return;
    end
    fast  = is_fast(op, a, b);
    t_acc = cyc + 1;
    e.res = model(op, a, b); e.rd = rd; e.due = fast ? t_acc : t_acc + 33;
    exp_q.push_back(e);
    st = stall_AGEX ? 1 : 0;
    n = 0;
    do begin
      @(negedge clk); #1;
      if (stall_AGEX) st++;
      n++;
    end while (stall_AGEX && n < 100);
    chk("stall_cycles", 32'(st), fast ? 32'd1 : 32'd34);
    req_valid = 1'b0;
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    @(negedge clk);
    drive(op, a, b, rd);
    complete(op, a, b, rd);
  endtask

  // Monitor: every resp_valid must match the oldest outstanding expectation, on its due cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk); #1;
      if (resp_valid) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_resp: result %h rd %0d at cycle %0d, none outstanding", resp_result, resp_rd, cyc);
        end else begin
          e = exp_q.pop_front();
          if (resp_result !== e.res || resp_rd !== e.rd || cyc != e.due) begin
            fails++;
            $display("FAIL resp: result %h rd %0d cycle %0d, expected result %h rd %0d cycle %0d",
                     resp_result, resp_rd, cyc, e.res, e.rd, e.due);
          end
        end
      end
    end
  end

  typedef struct { logic [2:0] op; logic [31:0] a; logic [31:0] b; logic [4:0] rd; } vec_t;
  vec_t dir[14];

  initial begin
    logic [2:0]  rop;
    logic [31:0] ra, rb;
    dir[0]  = '{3'd0, 32'd7,        32'hFFFF_FFFD, 5'd5};
    dir[1]  = '{3'd1, MINV,         MINV,          5'd1};
    dir[2]  = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2};
    dir[3]  = '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3};
    dir[4]  = '{3'd4, 32'hFFFF_FFF9, 32'd2,        5'd4};
    dir[5]  = '{3'd6, 32'hFFFF_FFF9, 32'd2,        5'd6};
    dir[6]  = '{3'd5, 32'd100,      32'd7,         5'd7};
    dir[7]  = '{3'd7, 32'd100,      32'd7,         5'd8};
    dir[8]  = '{3'd5, 32'd5,        32'd0,         5'd9};
    dir[9]  = '{3'd7, 32'd5,        32'd0,         5'd10};
    dir[10] = '{3'd4, MINV,         32'hFFFF_FFFF, 5'd11};
    dir[11] = '{3'd6, MINV,         32'hFFFF_FFFF, 5'd12};
    dir[12] = '{3'd4, 32'hFFFF_FFF0, 32'd0,        5'd13};
    dir[13] = '{3'd6, 32'hFFFF_FFF0, 32'd0,        5'd14};

    reset = 1'b1; req_valid = 1'b0; flush = 1'b0;
    req_op = '0; req_rs1 = '0; req_rs2 = '0; req_rd = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_valid", 32'(resp_valid), 32'd0);
    chk("rst_result", resp_result, 32'd0);
    chk("rst_rd", 32'(resp_rd), 32'd0);
    chk("rst_stall", 32'(stall_AGEX), 32'd0);

    foreach (dir[i]) issue(dir[i].op, dir[i].a, dir[i].b, dir[i].rd);

    // Flush mid-CALC: killed MUL never responds; replacement op accepted the cycle after.
    begin
      int t;
      @(negedge clk);
      drive(3'd0, 32'd12345, 32'd678, 5'd20);
      #1;
      t = 0;
      while (!req_ready && t < 100) begin @(negedge clk); #1; t++; end
      @(posedge clk);
      repeat (10) @(negedge clk);
      flush = 1'b1;
      drive(3'd5, 32'd1000, 32'd33, 5'd21);
      @(negedge clk);
      flush = 1'b0;
      #1;
      chk("flush_idle_ready", 32'(req_ready), 32'd1);
      complete(3'd5, 32'd1000, 32'd33, 5'd21);
    end

    // Flush in the DONE cycle of a fast-path op suppresses the strobe.
    @(negedge clk);
    drive(3'd5, 32'd9, 32'd0, 5'd22);
    #1;
    chk("fast_ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    #1;
    chk("flush_done_valid", 32'(resp_valid), 32'd0);
    @(negedge clk);
    flush = 1'b0; req_valid = 1'b0;
    #1;
    chk("flush_done_ready", 32'(req_ready), 32'd1);

    // Reset mid-CALC clears the sequencer and the held result.
    @(negedge clk);
    drive(3'd1, 32'h1234_5678, 32'h9ABC_DEF0, 5'd23);
    @(posedge clk);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; req_valid = 1'b0;
    #1;
    chk("midrst_ready", 32'(req_ready), 32'd1);
    chk("midrst_valid", 32'(resp_valid), 32'd0);
    chk("midrst_result", resp_result, 32'd0);
    chk("midrst_rd", 32'(resp_rd), 32'd0);
    chk("midrst_stall", 32'(stall_AGEX), 32'd0);

    for (int k = 0; k < 40; k++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = rnd_opnd();
      rb  = rnd_opnd();
      repeat ($urandom_range(0, 2)) @(negedge clk);
      issue(rop, ra, rb, 5'($urandom_range(0, 31)));
    end

    repeat (5) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
